// File: rtl/rr_index_arbiter_pkg.sv
// rr_arb_pkg: shared FSM state type and default index width for the round-robin index arbiter.
package rr_arb_pkg;
    typedef enum logic {IDLE, GRANT} rr_state_t;
    localparam int RR_N_DEFAULT = 3;
endpackage

// File: rtl/rr_index_arbiter_pick.sv
// rr_pick: combinational rotating-priority picker; first set req bit scanning upward from ptr, wrapping.
module rr_pick #(
    parameter int N = 3
) (
    input  logic [(1<<N)-1:0] req,
    input  logic [N-1:0]      ptr,
    output logic              hit,
    output logic [N-1:0]      idx
);
    // Walk offsets from farthest to nearest so the nearest set bit is assigned last and wins.
    always_comb begin
        idx = ptr;
        for (int i = (1<<N)-1; i >= 0; i--)
            if (req[ptr + N'(i)]) idx = ptr + N'(i);
    end
    assign hit = |req;
endmodule

// File: rtl/rr_index_arbiter.sv
// rr_index_arbiter: round-robin arbiter over 1<<N requesters, grant held until gnt_ack.
// Optional watchdog release with timeout pulse when RR_ARB_TIMEOUT_EN is defined.
module rr_index_arbiter
    import rr_arb_pkg::*;
#(
    parameter int N           = RR_N_DEFAULT,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [(1<<N)-1:0] req,
    output logic [N-1:0]      gnt_idx,
    output logic              gnt_valid,
    input  logic              gnt_ack
`ifdef RR_ARB_TIMEOUT_EN
    ,
    output logic              timeout
`endif
);
    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be >= 2");
    end

    rr_state_t      state_q, state_d;
    logic [N-1:0]   gnt_idx_q, gnt_idx_d, ptr_q, ptr_d, pick_idx;
    logic           gnt_valid_q, gnt_valid_d, pick_hit, rel;

    rr_pick #(.N(N)) u_pick (.req(req), .ptr(ptr_q), .hit(pick_hit), .idx(pick_idx));

`ifdef RR_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC);
    logic [CW-1:0] wd_cnt_q, wd_cnt_d;
    logic          timeout_q, timeout_d, wd_fire;
    // gnt_ack wins over a coincident watchdog expiry, so no pulse in that case.
    assign wd_fire   = state_q == GRANT && !gnt_ack && wd_cnt_q == CW'(TIMEOUT_CYC - 1);
    assign rel       = gnt_ack || wd_fire;
    assign wd_cnt_d  = (state_q == GRANT && !rel) ? wd_cnt_q + 1'b1 : '0;
    assign timeout_d = wd_fire;
    assign timeout   = timeout_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
`else
    assign rel = gnt_ack;
`endif

    always_comb begin
        state_d     = state_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        ptr_d       = ptr_q;
        if (state_q == IDLE) begin
            if (pick_hit) begin
                gnt_idx_d   = pick_idx;
                gnt_valid_d = 1'b1;
                state_d     = GRANT;
            end
        end else if (rel) begin
            ptr_d       = gnt_idx_q + 1'b1;
            gnt_valid_d = 1'b0;
            state_d     = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q     <= IDLE;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            state_q     <= state_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            ptr_q       <= ptr_d;
        end

    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;
endmodule

// File: tb/tb_rr_index_arbiter.sv
// tb_rr_index_arbiter: directed and randomized checks of rr_index_arbiter against a behavioural model.
module tb_rr_index_arbiter;
    localparam int N  = 3;
    localparam int W  = 1 << N;
    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] req;
    logic [N-1:0] gnt_idx;
    logic         gnt_valid;
    logic         gnt_ack;
`ifdef RR_ARB_TIMEOUT_EN
    logic         timeout;
`endif

    int checks = 0;
    int failures = 0;
    int m_ptr, m_idx, m_cnt;
    bit m_valid, m_to;

    rr_index_arbiter #(.N(N), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .gnt_idx(gnt_idx),
        .gnt_valid(gnt_valid), .gnt_ack(gnt_ack)
`ifdef RR_ARB_TIMEOUT_EN
        , .timeout(timeout)
`endif
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_ptr = 0; m_idx = 0; m_cnt = 0; m_valid = 0; m_to = 0;
    endtask

    task automatic model_release();
        m_ptr   = (m_idx + 1) % W;
        m_valid = 0;
    endtask

    // One clock of the arbitration rules, applied to the inputs present at the edge.
    task automatic model_edge();
        bit found;
        m_to = 0;
        if (rst) model_reset();
        else if (!m_valid) begin
            found = 0;
            for (int off = 0; off < W; off++)
                if (!found && req[(m_ptr + off) % W]) begin
                    found = 1;
                    m_idx = (m_ptr + off) % W;
                end
            if (found) begin
                m_valid = 1;
                m_cnt   = 0;
            end
        end else if (gnt_ack) model_release();
`ifdef RR_ARB_TIMEOUT_EN
        else if (m_cnt == TO - 1) begin
            model_release();
            m_to = 1;
        end else m_cnt++;
`endif
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if (gnt_valid !== 1'b0 || gnt_idx !== 3'd0) begin
            failures++;
            $display("FAIL reset_state valid=%0b idx=%0d want valid=0 idx=0", gnt_valid, gnt_idx);
        end
        rst = 0; req = 8'h20; cyc();
        checks++;
        if (gnt_valid !== 1'b1 || gnt_idx !== 3'd5) begin
            failures++;
            $display("FAIL reset_pre_grant valid=%0b idx=%0d want valid=1 idx=5", gnt_valid, gnt_idx);
        end
        req = 8'h20; gnt_ack = 1; cyc(); gnt_ack = 0; req = 8'h00; cyc();
        req = 8'h20; cyc();
        #2 rst = 1;
        #1;
        model_reset();
        checks++;
        if (gnt_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_async_drop valid=%0b want 0", gnt_valid);
        end
        cyc(); rst = 0; req = 8'h20; cyc();
        checks++;
        if (gnt_valid !== 1'b1 || gnt_idx !== 3'd5) begin
            failures++;
            $display("FAIL reset_regrant valid=%0b idx=%0d want valid=1 idx=5", gnt_valid, gnt_idx);
        end
        gnt_ack = 1; req = 0; cyc(); gnt_ack = 0;
    endtask

    task automatic test_rotation();
        int start;
        req = '1;
        start = m_ptr;
        for (int g = 0; g < 9; g++) begin
            cyc();
            checks++;
            if (gnt_valid !== 1'b1 || gnt_idx !== 3'((start + g) % W)) begin
                failures++;
                $display("FAIL rotation_grant%0d valid=%0b idx=%0d want valid=1 idx=%0d", g, gnt_valid, gnt_idx, (start + g) % W);
            end
            gnt_ack = 1; cyc(); gnt_ack = 0;
            checks++;
            if (gnt_valid !== 1'b0) begin
                failures++;
                $display("FAIL rotation_bubble%0d valid=%0b want 0", g, gnt_valid);
            end
        end
        req = 0;
    endtask

    task automatic test_wrap();
        req = 8'h20; cyc(); gnt_ack = 1; req = 0; cyc(); gnt_ack = 0;
        req = 8'h41; cyc();
        checks++;
        if (gnt_valid !== 1'b1 || gnt_idx !== 3'd6) begin
            failures++;
            $display("FAIL wrap_ptr6 valid=%0b idx=%0d want valid=1 idx=6", gnt_valid, gnt_idx);
        end
        gnt_ack = 1; req = 0; cyc(); gnt_ack = 0;
        req = 8'h01; cyc();
        checks++;
        if (gnt_valid !== 1'b1 || gnt_idx !== 3'd0) begin
            failures++;
            $display("FAIL wrap_to0 valid=%0b idx=%0d want valid=1 idx=0", gnt_valid, gnt_idx);
        end
        gnt_ack = 1; req = 0; cyc(); gnt_ack = 0;
        req = 8'h80; cyc(); gnt_ack = 1; req = 0; cyc(); gnt_ack = 0;
        req = 8'h01; cyc();
        checks++;
        if (gnt_valid !== 1'b1 || gnt_idx !== 3'd0) begin
            failures++;
            $display("FAIL wrap_after7 valid=%0b idx=%0d want valid=1 idx=0", gnt_valid, gnt_idx);
        end
        gnt_ack = 1; req = 0; cyc(); gnt_ack = 0;
    endtask

    task automatic test_lock();
        req = 8'h08; cyc();
        req = 8'h02;
        for (int k = 0; k < 5; k++) begin
            cyc();
            checks++;
            if (gnt_valid !== 1'b1 || gnt_idx !== 3'd3) begin
                failures++;
                $display("FAIL lock_hold%0d valid=%0b idx=%0d want valid=1 idx=3", k, gnt_valid, gnt_idx);
            end
        end
        gnt_ack = 1; cyc(); gnt_ack = 0;
        checks++;
        if (gnt_valid !== 1'b0) begin
            failures++;
            $display("FAIL lock_release valid=%0b want 0", gnt_valid);
        end
        cyc();
        checks++;
        if (gnt_valid !== 1'b1 || gnt_idx !== 3'd1) begin
            failures++;
            $display("FAIL lock_next valid=%0b idx=%0d want valid=1 idx=1", gnt_valid, gnt_idx);
        end
        gnt_ack = 1; req = 0; cyc(); gnt_ack = 0;
    endtask

    task automatic test_stray_ack();
        req = 0; gnt_ack = 1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            checks++;
            if (gnt_valid !== 1'b0) begin
                failures++;
                $display("FAIL stray_ack%0d valid=%0b want 0", k, gnt_valid);
            end
        end
        gnt_ack = 0; req = '1; cyc();
        checks++;
        if (gnt_valid !== 1'b1 || gnt_idx !== 3'd2) begin
            failures++;
            $display("FAIL stray_ptr valid=%0b idx=%0d want valid=1 idx=2", gnt_valid, gnt_idx);
        end
        gnt_ack = 1; req = 0; cyc(); gnt_ack = 0;
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            req     = W'($urandom);
            if ($urandom_range(0, 3) == 0) req = W'(1 << $urandom_range(0, W - 1));
            gnt_ack = ($urandom_range(0, 2) == 0);
            cyc();
            checks++;
            if (gnt_valid !== m_valid || (m_valid && gnt_idx !== 3'(m_idx))) begin
                failures++;
                $display("FAIL random_cyc%0d valid=%0b idx=%0d want valid=%0b idx=%0d", k, gnt_valid, gnt_idx, m_valid, m_idx);
            end
        end
        req = 0; gnt_ack = 1; cyc(); gnt_ack = 0; cyc();
    endtask

`ifdef RR_ARB_TIMEOUT_EN
    task automatic test_timeout();
        for (int rep = 0; rep < 2; rep++) begin
            req = 8'h10; cyc(); req = 0;
            for (int k = 1; k < TO; k++) begin
                cyc();
                checks++;
                if (gnt_valid !== 1'b1 || timeout !== 1'b0) begin
                    failures++;
                    $display("FAIL timeout_hold%0d_%0d valid=%0b to=%0b want valid=1 to=0", rep, k, gnt_valid, timeout);
                end
            end
            gnt_ack = (rep == 1); cyc(); gnt_ack = 0;
            checks++;
            if (gnt_valid !== 1'b0 || timeout !== (rep == 0) || timeout !== m_to) begin
                failures++;
                $display("FAIL timeout_fire%0d valid=%0b to=%0b want valid=0 to=%0b", rep, gnt_valid, timeout, rep == 0);
            end
            cyc();
            checks++;
            if (timeout !== 1'b0) begin
                failures++;
                $display("FAIL timeout_pulse_end%0d to=%0b want 0", rep, timeout);
            end
        end
    endtask
`endif

    initial begin
        rst = 1; req = 0; gnt_ack = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_rotation();
        test_wrap();
        test_lock();
        test_stray_ack();
        test_random();
`ifdef RR_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rr_index_arbiter.md
Name: rr_index_arbiter

Overview:
Round-robin arbiter over 1<<N requesters; emits the winning requester as a binary index plus a valid flag.
Sits directly upstream of the 3-to-8 one-hot decoder (decode_3_input): gnt_idx drives the decoder's de_in, and the decoder's de_out becomes the one-hot grant bus.
Grant is held until the consumer acknowledges, then priority rotates past the winner.

Parameters:
N, 3, index width; number of requesters = 1<<N.
TIMEOUT_CYC, 16, watchdog limit in cycles (used only when RR_ARB_TIMEOUT_EN is defined); must be >= 2.

Ports:
clk  input  1  clock; all state on rising edge.
rst  input  1  reset, asynchronous, active-high.
req  input  1<<N  request vector; bit i = requester i wants the resource.
gnt_idx  output  N  index of the granted requester; valid only when gnt_valid=1.
gnt_valid  output  1  a grant is currently held.
gnt_ack  input  1  consumer releases the current grant; sampled only while gnt_valid=1.
timeout  output  1  one-cycle pulse on watchdog release (present only when RR_ARB_TIMEOUT_EN is defined).

Behaviour:
- One clock, clk. Reset is asynchronous and active-high on rst.
- Reset values: gnt_valid=0, gnt_idx=0, rotation pointer ptr=0, state=IDLE, timeout=0, watchdog count=0.
- State IDLE:
  - if req != 0, select the first set bit of req scanning cyclically from index ptr upward (ptr, ptr+1, ..., wrapping modulo 1<<N).
  - register that index into gnt_idx, set gnt_valid=1, go to GRANT.
  - latency: req seen at edge k -> gnt_valid=1 after edge k.
  - if req == 0, stay in IDLE with outputs unchanged (gnt_valid=0).
- State GRANT:
  - gnt_idx and gnt_valid are held stable regardless of req (the grant is locked, even if the winner drops its req bit).
  - on gnt_ack=1: ptr <= gnt_idx+1, wrapping from (1<<N)-1 to 0 (natural N-bit overflow); gnt_valid <= 0; go to IDLE.
- Throughput: minimum spacing between successive grants is 2 cycles (a one-cycle IDLE bubble after each ack).
- gnt_ack while in IDLE is ignored and causes no state change.
- Boundary conditions:
  - all req bits set: grants cycle 0, 1, ..., 7, 0, ... in order.
  - single requester: that requester wins repeatedly; ptr still advances past it.
  - ptr = 7 and req = 8'b0000_0001: grant index 0 (wrap).
  - req changing in the same cycle as ack: the next arbitration uses the req sampled in the following IDLE cycle.
- rst asserted mid-grant: gnt_valid drops immediately (asynchronously) and ptr returns to 0.

Optional Feature:
Macro RR_ARB_TIMEOUT_EN.
- Defined:
  - a counter runs while in GRANT and clears on entry to GRANT.
  - if it reaches TIMEOUT_CYC-1 without gnt_ack, the arbiter behaves exactly as if gnt_ack had been asserted (ptr advances, return to IDLE).
  - the timeout port pulses 1 for that cycle.
  - a simultaneous gnt_ack takes precedence, and timeout stays 0.
- Not defined: no counter and no timeout port; a grant is held indefinitely until gnt_ack.

Decomposition:
Package rr_arb_pkg holds:
- typedef enum logic {IDLE, GRANT} rr_state_t;
- localparam RR_N_DEFAULT = 3.
One natural sub-module: rr_pick, a combinational rotating-priority picker. Inputs req and ptr; outputs hit and idx.

Test Plan:
- Reset behaviour: assert rst mid-GRANT with gnt_idx=5 -> gnt_valid=0 immediately. After release, req=8'h20 -> gnt_idx=5, since ptr was reset to 0 and the first set bit from 0 is bit 5.
- Full rotation: req=8'hFF held, ack one cycle after each grant -> gnt_idx sequence 0,1,2,3,4,5,6,7,0, with grants spaced 2 cycles apart.
- Wrap: drive grant 7 then ack, then req=8'h01 -> gnt_idx=0. Also: ptr=6 and req=8'h41 -> gnt_idx=6; after ack, ptr=7 and the next grant is 0.
- Lock: grant idx 3, drop req[3] and raise req[1] without ack -> gnt_idx stays 3 and gnt_valid stays 1 until ack.
- Stray ack: gnt_ack=1 with req=0 in IDLE -> no grant, ptr unchanged.
- With RR_ARB_TIMEOUT_EN, TIMEOUT_CYC=16: hold a grant with no ack -> timeout pulses 16 cycles after gnt_valid rose, then gnt_valid=0. Repeat with ack in that same cycle -> timeout=0.
